// File: rtl/instr_exec_unit.sv
// Sequential instruction executor: walks a run of entries in an external
// instruction register, executes each on a signed ALU and hands results out.
module instr_exec_unit #(
  parameter int ADDR_W = 5,
  parameter int OPND_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W:0]         count,
  output logic [ADDR_W-1:0]       read_pointer,
  input  logic [4+2*OPND_W-1:0]   instruction_word,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [2*OPND_W-1:0]     result,
  output logic [ADDR_W-1:0]       res_addr,
  output logic                    res_err,
  output logic                    done
);

  localparam int RES_W = 2*OPND_W;
  localparam logic [ADDR_W:0]   REM_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} state_t;

  typedef struct packed {
    logic [3:0]               op;
    logic signed [OPND_W-1:0] a;
    logic signed [OPND_W-1:0] b;
  } instr_t;

  state_t             state, state_nxt;
  logic [ADDR_W:0]    remaining;
  instr_t             ir;
  logic [ADDR_W-1:0]  ir_addr;
  logic               hs;

  logic signed [RES_W-1:0] a_x, b_x, alu_res;
  logic                    alu_err;

  assign hs   = res_valid && res_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = OUT;
      OUT:     if (hs) state_nxt = (remaining == REM_ONE) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands widened first so MULT yields the full product and
  // MIN/-1 division cannot overflow.
  always_comb begin
    a_x     = {{OPND_W{ir.a[OPND_W-1]}}, ir.a};
    b_x     = {{OPND_W{ir.b[OPND_W-1]}}, ir.b};
    alu_res = '0;
    alu_err = 1'b0;
    case (ir.op)
      4'd0: alu_res = '0;
      4'd1: alu_res = a_x;
      4'd2: alu_res = b_x;
      4'd3: alu_res = a_x + b_x;
      4'd4: alu_res = a_x - b_x;
      4'd5: alu_res = a_x * b_x;
      4'd6: if (b_x == '0) alu_err = 1'b1; else alu_res = a_x / b_x;
      4'd7: if (b_x == '0) alu_err = 1'b1; else alu_res = a_x % b_x;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      ir           <= '0;
      ir_addr      <= '0;
      res_valid    <= 1'b0;
      result       <= '0;
      res_addr     <= '0;
      res_err      <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nxt;
      // done is registered, so it pulses in the cycle after DONE.
      done  <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          read_pointer <= start_addr;
          remaining    <= count;
        end
        FETCH: begin
          ir      <= instr_t'(instruction_word);
          ir_addr <= read_pointer;
        end
        EXEC: begin
          result    <= alu_res;
          res_addr  <= ir_addr;
          res_err   <= alu_err;
          res_valid <= 1'b1;
        end
        OUT: if (hs) begin
          res_valid <= 1'b0;
          remaining <= remaining - REM_ONE;
          if (remaining != REM_ONE) read_pointer <= read_pointer + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed scenarios plus random runs checked
// every cycle against a transaction-level model.
module tb_instr_exec_unit;
  localparam int AW = 5;
  localparam int OW = 32;
  localparam int IW = 4 + 2*OW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] read_pointer;
  logic [IW-1:0] instruction_word;
  logic          busy, res_valid, res_err, done;
  logic          res_ready = 1'b0;
  logic [2*OW-1:0] result;
  logic [AW-1:0] res_addr;

  logic [IW-1:0] mem [32];
  assign instruction_word = mem[read_pointer];

  instr_exec_unit #(.ADDR_W(AW), .OPND_W(OW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .count(count), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .res_addr(res_addr),
    .res_err(res_err), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU in plain 64-bit signed arithmetic: {err, result}.
  function automatic logic [64:0] ref_op(input logic [3:0] op, input int a, input int b);
    longint x = a;
    longint y = b;
    longint r = 0;
    bit     e = 1'b0;
    case (op)
      4'd0: r = 0;
      4'd1: r = x;
      4'd2: r = y;
      4'd3: r = x + y;
      4'd4: r = x - y;
      4'd5: r = x * y;
      4'd6: if (y == 0) e = 1'b1; else r = x / y;
      4'd7: if (y == 0) e = 1'b1; else r = x % y;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input int a, input int b);
    return {op, a, b};
  endfunction

  function automatic int rnd_opnd();
    case ($urandom % 6)
      0: return 0;
      1: return -1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  function automatic logic [IW-1:0] rnd_ins();
    logic [3:0] op = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 8);
    return ins(op, rnd_opnd(), rnd_opnd());
  endfunction

  // Transaction-level model: a run is a list of addresses; each result
  // shows up two edges after the run starts or after the previous handshake.
  logic          m_busy, m_vld, m_done, m_err, m_fin;
  logic [63:0]   m_res;
  logic [AW-1:0] m_addr, m_ptr;
  int            m_left, m_gap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_vld <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_fin  <= 1'b0; m_res <= '0;   m_addr <= '0;   m_ptr <= '0;
      m_left <= 0;    m_gap <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_left <= int'(count);
          m_ptr  <= start_addr;
          m_fin  <= (count == '0);
          m_gap  <= (count == '0) ? 0 : 2;
        end
      end else if (m_fin) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_fin  <= 1'b0;
      end else if (m_gap > 0) begin
        m_gap <= m_gap - 1;
        if (m_gap == 1) begin
          m_vld <= 1'b1;
          {m_err, m_res} <= ref_op(mem[m_ptr][IW-1 -: 4], mem[m_ptr][2*OW-1 -: OW], mem[m_ptr][OW-1:0]);
          m_addr <= m_ptr;
        end
      end else if (m_vld && res_ready) begin
        m_vld  <= 1'b0;
        m_left <= m_left - 1;
        if (m_left == 1) m_fin <= 1'b1;
        else begin
          m_ptr <= m_ptr + 1'b1;
          m_gap <= 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_busy);
      chk("res_valid", res_valid, m_vld);
      chk("done", done, m_done);
      if (m_vld) begin
        chk("result", result, m_res);
        chk("res_addr", res_addr, m_addr);
        chk("res_err", res_err, m_err);
      end
    end
  end

  logic [63:0]   rr [8];
  logic [AW-1:0] ra [8];
  logic          re [8];

  task automatic go(input logic [AW-1:0] sa, input int cnt);
    start = 1'b1; start_addr = sa; count = (AW+1)'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_vld(output int n);
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic collect(input int lim, output int k, output int dones);
    k = 0; dones = 0;
    for (int i = 0; i < lim; i++) begin
      if (res_valid && res_ready && k < 8) begin
        rr[k] = result; ra[k] = res_addr; re[k] = res_err; k++;
      end
      if (done) dones++;
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_addr"}, res_addr, 0);
    chk({tag, "_err"}, res_err, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdptr"}, read_pointer, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k, d, cv;
    logic [64:0] p;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Pin the reference model on hand-computed values.
    p = ref_op(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF); chk("pin_mult", p, {1'b0, 64'h3FFF_FFFF_0000_0001});
    p = ref_op(4'd6, -7, 2);  chk("pin_div", p, {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    p = ref_op(4'd7, -7, 2);  chk("pin_mod", p, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    p = ref_op(4'd6, 9, 0);   chk("pin_div0", p, {1'b1, 64'h0});
    p = ref_op(4'd12, 1, 1);  chk("pin_badop", p, {1'b1, 64'h0});

    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    chk_on = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Single ADD, latency and done.
    mem[3] = ins(4'd3, 5, -7);
    res_ready = 1'b1;
    go(5'd3, 1);
    wait_vld(n);
    chk("t1_latency", n, 3);
    chk("t1_result", result, -2);
    chk("t1_addr", res_addr, 3);
    chk("t1_err", res_err, 0);
    collect(6, k, d);
    chk("t1_done", d, 1);
    chk("t1_busy", busy, 0);

    // Run wrapping 31 -> 0.
    mem[30] = ins(4'd5, -3, 4);
    mem[31] = ins(4'd4, 1, 2);
    mem[0]  = ins(4'd6, -7, 2);
    mem[1]  = ins(4'd7, -7, 2);
    go(5'd30, 4);
    collect(30, k, d);
    chk("t2_count", k, 4);
    chk("t2_r0", rr[0], -12); chk("t2_a0", ra[0], 30);
    chk("t2_r1", rr[1], -1);  chk("t2_a1", ra[1], 31);
    chk("t2_r2", rr[2], -3);  chk("t2_a2", ra[2], 0);
    chk("t2_r3", rr[3], -1);  chk("t2_a3", ra[3], 1);
    chk("t2_done", d, 1);

    // Error cases do not end the run.
    mem[5] = ins(4'd6, 9, 0);
    mem[6] = ins(4'd12, 1, 1);
    go(5'd5, 2);
    collect(20, k, d);
    chk("t3_count", k, 2);
    chk("t3_r0", rr[0], 0); chk("t3_e0", re[0], 1);
    chk("t3_r1", rr[1], 0); chk("t3_e1", re[1], 1);
    chk("t3_done", d, 1);

    // Backpressure with ignored start pulses.
    mem[10] = ins(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    res_ready = 1'b0;
    go(5'd10, 1);
    wait_vld(n);
    chk("t4_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; start_addr = 5'd7; count = 6'd3;
      @(negedge clk);
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_result", result, 64'h3FFF_FFFF_0000_0001);
      chk("t4_hold_addr", res_addr, 10);
    end
    start = 1'b0;
    res_ready = 1'b1;
    collect(8, k, d);
    chk("t4_count", k, 1);
    chk("t4_done", d, 1);

    // Empty run.
    go(5'd0, 0);
    chk("t5_done_e1", done, 0);
    chk("t5_busy_e1", busy, 1);
    @(negedge clk);
    chk("t5_done_e2", done, 1);
    chk("t5_valid", res_valid, 0);
    @(negedge clk);
    chk("t5_done_e3", done, 0);

    // Reset in OUT, then a fresh run.
    mem[2] = ins(4'd3, 1, 1);
    res_ready = 1'b0;
    go(5'd2, 1);
    wait_vld(n);
    chk("t6_valid", res_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("t6_rst");
    @(negedge clk);
    reset_n = 1'b1;
    collect(5, k, d);
    chk("t6_no_res", k, 0);
    chk("t6_no_done", d, 0);
    res_ready = 1'b1;
    go(5'd2, 1);
    collect(8, k, d);
    chk("t6_count", k, 1);
    chk("t6_result", rr[0], 2);
    chk("t6_done", d, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset_n = 1'b1;
      if (!m_busy && ($urandom % 3 == 0))
        for (int i = 0; i < 32; i++) mem[i] = rnd_ins();
      cv = ($urandom % 10 < 2) ? 0 : ($urandom % 10 < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 32));
      start      = ($urandom % 4 == 0);
      start_addr = AW'($urandom);
      count      = (AW+1)'(cv);
      res_ready  = ($urandom % 10 < 7);
      if ($urandom % 200 == 0) begin
        #2 reset_n = 1'b0;
        #1 chk_all_zero("rnd_rst");
      end
    end
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0; res_ready = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_exec_unit.md
INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

Interface
REQ-001 Parameter ADDR_W, default 5, instruction register address width (32 entries).
REQ-002 Parameter OPND_W, default 32, signed operand width; result width is 2*OPND_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to execute a run of stored instructions; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  address of first instruction in the run.
REQ-007 count  input  ADDR_W+1  number of instructions in the run, 0..2**ADDR_W.
REQ-008 read_pointer  output  ADDR_W  read address driven to the instruction register.
REQ-009 instruction_word  input  4+2*OPND_W  packed {opcode[3:0], operand_a, operand_b}, combinational read of entry read_pointer.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 result  output  2*OPND_W  signed result.
REQ-014 res_addr  output  ADDR_W  address of the instruction that produced result.
REQ-015 res_err  output  1  result invalid (divide by zero or undefined opcode); qualified by res_valid.
REQ-016 done  output  1  one-cycle pulse at end of run.

Function
REQ-017 The block SHALL be a state machine with states IDLE, FETCH, EXEC, OUT, DONE.
REQ-018 IDLE: start=1 -> latch start_addr into read_pointer and count into remaining; count=0 -> DONE, else -> FETCH.
REQ-019 FETCH (one cycle): capture instruction_word and read_pointer into internal registers -> EXEC.
REQ-020 EXEC (one cycle): register result, res_addr, res_err; assert res_valid -> OUT.
REQ-021 Latency: res_valid SHALL rise exactly 3 clock edges after the edge sampling start (IDLE->FETCH->EXEC->OUT).
REQ-022 OUT: result, res_addr, res_err, res_valid held stable until res_valid && res_ready at a clock edge.
REQ-023 On handshake in OUT: decrement remaining; remaining was 1 -> DONE, else read_pointer increments and -> FETCH.
REQ-024 read_pointer increment SHALL wrap modulo 2**ADDR_W (31 -> 0 for ADDR_W=5).
REQ-025 res_ready asserted while res_valid=0 SHALL have no effect.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE; start SHALL be ignored in every state except IDLE, including DONE.
REQ-027 Opcodes: 0 ZERO ->0; 1 PASSA ->a; 2 PASSB ->b; 3 ADD ->a+b; 4 SUB ->a-b; 5 MULT ->a*b; 6 DIV ->a/b; 7 MOD ->a%b.
REQ-028 Operands SHALL be sign-extended to 2*OPND_W before arithmetic; MULT yields the full signed product without overflow.
REQ-029 DIV truncates toward zero; MOD takes the sign of the dividend.
REQ-030 DIV or MOD with b=0 SHALL give result=0, res_err=1.
REQ-031 Opcodes 8..15 SHALL give result=0, res_err=1.
REQ-032 res_err=0 for all other cases; an erroring instruction SHALL still require a handshake and SHALL NOT end the run.

Reset
REQ-033 reset_n=0 SHALL immediately, without a clock edge, force IDLE, read_pointer=0, remaining=0, busy=0, res_valid=0, result=0, res_addr=0, res_err=0, done=0.
REQ-034 Reset mid-run SHALL abandon the run with no done pulse; after release, the block waits for a new start.
REQ-035 Release of reset_n SHALL take effect on the next rising clk edge; start sampled on that edge SHALL be accepted.

Verification
REQ-036 Instruction at addr 3 = {ADD, 5, -7}; start, start_addr=3, count=1, res_ready=1 -> res_valid 3 edges after start, result=-2, res_addr=3, res_err=0, then done pulse, busy=0.
REQ-037 Run start_addr=30, count=4 with MULT {-3,4}, SUB {1,2}, DIV {-7,2}, MOD {-7,2} at 30,31,0,1 -> results -12, -1, -3, -1 with res_addr 30,31,0,1 (wrap).
REQ-038 DIV {9,0}, then opcode 12 -> both result=0, res_err=1; run completes; done pulses once.
REQ-039 res_ready=0 for 5 cycles in OUT -> result, res_addr, res_valid stable; start pulses during the run are ignored; MULT {32'h7FFFFFFF,32'h7FFFFFFF} -> 64'h3FFFFFFF00000001.
REQ-040 count=0 -> no res_valid; done pulses 2 edges after start.
REQ-041 reset_n low for one cycle while in OUT -> all outputs 0 immediately, no done pulse; new start with count=1 -> normal completion.
